// File: rtl/display_scan_controller.sv
// Scan sequencer for a 4-digit multiplexed seven-segment display.
// Snapshots the count per frame, lights each digit, then blanks.
module display_scan_controller #(
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        lz_en,
    input  logic [15:0] count,
    output logic [3:0]  digit_select,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ON,
        S_BLANK
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST =
        CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      snap_q, snap_d;
    logic [3:0]       ds_q, ds_d;
    logic [3:0]       nib_q, nib_d;
    logic             fd_q, fd_d;

    logic [15:0]      shifted;
    logic             supp;
    logic             lit;
    logic             last_digit;

    assign last_digit = (idx_q == 2'd3);

    // Next-state sequencing; outputs are precomputed for the state being entered
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        fd_d    = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                snap_d = count;
                idx_d  = 2'd0;
                cnt_d  = '0;
                if (enable) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (!enable) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (HAS_BLANK) begin
                        state_d = S_BLANK;
                    end else if (last_digit) begin
                        state_d = S_LOAD;
                        fd_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BLANK: begin
                if (!enable) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (last_digit) begin
                        state_d = S_LOAD;
                        fd_d    = 1'b1;
                    end else begin
                        state_d = S_ON;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        // A digit whose value and all higher digits are zero is leading zero
        shifted = snap_d >> {idx_d, 2'b00};
        supp    = lz_en && (idx_d != 2'd0) && (shifted == 16'h0000);
        lit     = (state_d == S_ON) && !supp;
        ds_d    = lit ? ~(4'b0001 << idx_d) : 4'b1111;
        nib_d   = lit ? shifted[3:0] : nib_q;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            snap_q  <= 16'h0000;
            ds_q    <= 4'b1111;
            nib_q   <= 4'h0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            ds_q    <= ds_d;
            nib_q   <= nib_d;
            fd_q    <= fd_d;
        end
    end

    assign digit_select = ds_q;
    assign nibble       = nib_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (with and without
// blanking gap) checked against a frame-position reference model.
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] count = 16'h0000;

    logic [3:0]  ds0, nib0, ds1, nib1;
    logic        fd0, fd1;

    int n_cmp = 0;
    int n_err = 0;

    display_scan_controller #(
        .ON_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(17)
    ) u0 (
        .clk(clk), .reset(reset), .enable(enable), .lz_en(lz_en),
        .count(count), .digit_select(ds0), .nibble(nib0),
        .frame_done(fd0)
    );

    display_scan_controller #(
        .ON_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(17)
    ) u1 (
        .clk(clk), .reset(reset), .enable(enable), .lz_en(lz_en),
        .count(count), .digit_select(ds1), .nibble(nib1),
        .frame_done(fd1)
    );

    always #5 clk = ~clk;

    // Reference model: frame position since the snapshot
    bit          m_load[2];
    int          m_pos[2];
    logic [15:0] m_snap[2];
    logic [3:0]  m_ds[2];
    logic [3:0]  m_nib[2];
    logic        m_fd[2];

    function automatic int on_c(int k);
        return 4;
    endfunction

    function automatic int bl_c(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_load[k] = 1'b1;
            m_pos[k]  = 0;
            m_snap[k] = 16'h0000;
            m_ds[k]   = 4'b1111;
            m_nib[k]  = 4'h0;
            m_fd[k]   = 1'b0;
        end
    endtask

    task automatic m_step(int k);
        int per, d, r;
        logic [15:0] s;
        per = on_c(k) + bl_c(k);
        if (m_load[k]) begin
            m_snap[k] = count;
            m_fd[k]   = 1'b0;
            if (enable) begin
                m_load[k] = 1'b0;
                m_pos[k]  = 0;
            end
        end else if (!enable) begin
            m_load[k] = 1'b1;
            m_fd[k]   = 1'b0;
        end else begin
            m_pos[k]++;
            if (m_pos[k] == 4 * per) begin
                m_load[k] = 1'b1;
                m_fd[k]   = 1'b1;
            end else begin
                m_fd[k] = 1'b0;
            end
        end
        m_ds[k] = 4'b1111;
        if (!m_load[k]) begin
            d = m_pos[k] / per;
            r = m_pos[k] % per;
            s = m_snap[k] >> (4 * d);
            if (r < on_c(k) && !(lz_en && d >= 1 && s == 16'h0)) begin
                m_ds[k]  = ~(4'b0001 << d);
                m_nib[k] = s[3:0];
            end
        end
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ds0", {12'h0, ds0}, {12'h0, m_ds[0]});
        chk("nib0", {12'h0, nib0}, {12'h0, m_nib[0]});
        chk("fd0", {15'h0, fd0}, {15'h0, m_fd[0]});
        chk("ds1", {12'h0, ds1}, {12'h0, m_ds[1]});
        chk("nib1", {12'h0, nib1}, {12'h0, m_nib[1]});
        chk("fd1", {15'h0, fd1}, {15'h0, m_fd[1]});
        chk("onehot1", 16'($countones(~ds1) <= 1), 16'h1);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m_step(0);
            m_step(1);
            #1;
            check_all();
        end
    endtask

    // Step until model instance 0 sits at the requested digit/phase
    task automatic run_until(int dig, bit want_on, string tag);
        bit hit;
        int r;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            r = m_pos[0] % 6;
            if (!m_load[0] && (m_pos[0] / 6) == dig &&
                ((r < 4) == want_on)) begin
                hit = 1'b1;
            end else begin
                run(1);
            end
        end
        chk(tag, 16'(hit), 16'h1);
    endtask

    initial begin
        m_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_ds0", {12'h0, ds0}, 16'h000F);
        chk("rst_nib0", {12'h0, nib0}, 16'h0000);
        chk("rst_fd0", {15'h0, fd0}, 16'h0000);
        chk("rst_ds1", {12'h0, ds1}, 16'h000F);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        count = 16'h1234;
        lz_en = 1'b0;
        run(55);

        count = 16'h0050;
        lz_en = 1'b1;
        run(55);
        count = 16'h0000;
        run(55);

        count = 16'h1234;
        lz_en = 1'b0;
        run_until(1, 1'b1, "wait_d1_on");
        count = 16'hABCD;
        run(55);

        run_until(2, 1'b1, "wait_d2_on");
        enable = 1'b0;
        run(1);
        chk("dark_ds0", {12'h0, ds0}, 16'h000F);
        chk("dark_fd0", {15'h0, fd0}, 16'h0000);
        run(5);
        enable = 1'b1;
        run(30);

        run_until(1, 1'b0, "wait_blank");
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk("arst_ds0", {12'h0, ds0}, 16'h000F);
        chk("arst_fd0", {15'h0, fd0}, 16'h0000);
        chk("arst_nib0", {12'h0, nib0}, 16'h0000);
        chk("arst_ds1", {12'h0, ds1}, 16'h000F);
        #1 reset = 1'b0;
        run(40);

        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 9) == 0) begin
                count = 16'($urandom);
                if ($urandom_range(0, 1) == 0) begin
                    count = count >> (4 * $urandom_range(0, 3));
                end
            end
            if ($urandom_range(0, 19) == 0) begin
                lz_en = 1'($urandom);
            end
            run(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
